mioc_nandn_od: RTL
==================

# mioc_nandn_od

Parametrised N-input NAND gate with an open-drain output stage, a registered drive decision, synchronised bus readback and fault supervision. The block computes NAND of its inputs and, when the result is 0, pulls a shared wired-AND line low through `z_oe`; otherwise it releases the line to the external pullup. It sits wherever a MIOC open-drain NAND drives a shared or off-chip net. It adds clocking, enable, readback and stuck/open fault detection.

## Interface
- `N`, 2: number of NAND inputs, ≥2.
- `SYNC_STAGES`, 2: readback synchroniser depth, ≥2.
- `FAULT_CYCLES`, 16: consecutive mismatch cycles before a fault flag sets; must exceed `SYNC_STAGES`+1; max 255.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in`  in  N  NAND inputs, synchronous to `clk`.
- `en`  in  1  1 = gate active; 0 = output released regardless of `in`.
- `z_in`  in  1  readback of the wired line (asynchronous, pulled up externally).
- `clr_fault`  in  1  one-cycle pulse clears `stuck` and `open`.
- `z_oe`  out  1  pulldown enable; 1 = drive line low.
- `nand_q`  out  1  registered logic value the block requests (1 = released).
- `z`  out  1  synchronised line level.
- `stuck`  out  1  sticky: line held low by another driver while released.
- `open`  out  1  sticky: line failed to go low while driving.

## Operation
- Reset (`rst_n`=0 at edge): `nand_q`=1, `z_oe`=0, all synchroniser flops=1, `z`=1, `stuck`=0, `open`=0, counter=0, state RELEASED.
- Each edge: `nand_q` <= `en` ? ~&`in` : 1. `z_oe` = ~`nand_q` (combinational from register only; no path from `in`).
- Readback: `z_in` passes through `SYNC_STAGES` flops; last stage is `z`.
- FSM, two states, derived from `nand_q`: RELEASED (`nand_q`=1), DRIVING (`nand_q`=0).
- Mismatch: RELEASED with `z`=0, or DRIVING with `z`=1.
- Shared 8-bit counter: cleared to 0 on any state change or when no mismatch; otherwise increments, saturating at `FAULT_CYCLES`.
- On the edge where the counter goes from `FAULT_CYCLES`-1 to `FAULT_CYCLES`, set `stuck` (RELEASED) or `open` (DRIVING).
- Flags are sticky until `clr_fault` or reset. If `clr_fault` and a set occur on the same edge, set wins. The counter is not cleared by `clr_fault`, so a persisting fault remains saturated and does not re-set the flag until the counter restarts.
- `en` deassertion mid-drive releases the line on the next edge and clears the counter (state change). Flags are unaffected.
- Reset mid-fault: all state returns to reset values immediately at that edge.

## Timing
- `in`/`en` to `nand_q`/`z_oe`: 1 cycle.
- `z_in` to `z`: `SYNC_STAGES` cycles.
- Normal transition, loopback bus: mismatch lasts `SYNC_STAGES` cycles. This is below `FAULT_CYCLES` by constraint, so no flag sets.
- Persistent fault: flag asserts `FAULT_CYCLES` cycles after the first mismatch cycle (the first cycle with the counter at 1 counts as 1).
- Throughput: new `in` accepted every cycle; no handshake and no backpressure.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in`=all-1, `en`=1. Required: `z_oe`=0, `nand_q`=1, `z`=1, flags 0. Release reset: `z_oe`=1 on the next edge.
- Truth table, N=4, loopback `z_in`=~`z_oe`: sweep `in` 0x0..0xF with `en`=1. Required: `z_oe`=1 only for 0xF; `z` follows `SYNC_STAGES`=2 cycles later; no flags set.
- Enable gating: `in`=0xF, `en` toggled 1→0. Required: `z_oe` falls 1 cycle later; counter clears; no `open`.
- Stuck fault: `en`=0, force `z_in`=0 continuously. Required: `stuck`=1 exactly 16 cycles after `z` first reads 0; `open` stays 0. Pulse `clr_fault` while forced: `stuck` clears and stays 0 (counter saturated). Release the force, then force again: `stuck` sets after 16 cycles.
- Open fault: `in`=0xF, `en`=1, force `z_in`=1. Required: `open`=1 after 16 mismatch cycles. `clr_fault` coincident with the setting edge: `open` remains 1.
- Reset mid-fault: counter at 10 in RELEASED with `z`=0, assert `rst_n`=0 for one edge. Required: counter 0 and flags 0. The fault re-detects only after a full 16 mismatch cycles.

Source files
------------

// File: rtl/mioc_nandn_od.sv
`default_nettype none
// ============================================================================
//  Module   : mioc_nandn_od
//  Brief    : N-input NAND with registered open-drain drive decision,
//             synchronised line readback and stuck/open fault supervision.
//  Revision : 1.0 - initial release
// ============================================================================
module mioc_nandn_od #(
   parameter int N            = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int FAULT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in,
   input  logic         en,
   input  logic         z_in,
   input  logic         clr_fault,
   output logic         z_oe,
   output logic         nand_q,
   output logic         z,
   output logic         stuck,
   output logic         open
);

   localparam logic [7:0] c_fault_max = 8'(FAULT_CYCLES);

   // Reject parameter sets where a normal loopback transition could look like a fault.
   generate
      if (N < 2 || SYNC_STAGES < 2 || FAULT_CYCLES <= SYNC_STAGES + 1 || FAULT_CYCLES > 255) begin : g_param_check
         $error("mioc_nandn_od: illegal parameter combination");
      end
   endgenerate

   // The FSM state is the drive decision itself: RELEASED means nand_q = 1.
   typedef enum logic [0:0] {
      ST_RELEASED = 1'b0,
      ST_DRIVING  = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [7:0]             cnt_q, cnt_d;
   logic                   stuck_q, stuck_d;
   logic                   open_q, open_d;

   logic                   w_nand_next;
   logic                   w_state_change;
   logic                   w_mismatch;
   logic                   w_set;

   // Drive decision, fault counter and sticky flags register together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RELEASED;
         cnt_q   <= 8'd0;
         stuck_q <= 1'b0;
         open_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stuck_q <= stuck_d;
         open_q  <= open_d;
      end
   end

   // Readback synchroniser; resets to the released (pulled-up) level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], z_in};
      end
   end

   // Next state, mismatch counting and flag set/clear (set beats clear).
   always_comb begin
      w_nand_next    = 1'b1;
      state_d        = state_q;
      w_state_change = 1'b0;
      w_mismatch     = 1'b0;
      w_set          = 1'b0;
      cnt_d          = 8'd0;
      stuck_d        = stuck_q;
      open_d         = open_q;

      w_nand_next    = en ? ~&in : 1'b1;
      state_d        = w_nand_next ? ST_RELEASED : ST_DRIVING;
      w_state_change = (state_d != state_q);

      // Line level disagrees with what we asked for.
      w_mismatch = ((state_q == ST_RELEASED) && !z) ||
                   ((state_q == ST_DRIVING)  &&  z);

      if (w_state_change || !w_mismatch) begin
         cnt_d = 8'd0;
      end else if (cnt_q >= c_fault_max) begin
         cnt_d = c_fault_max;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      // Fires only on the single edge that reaches saturation.
      w_set = !w_state_change && w_mismatch && (cnt_q == c_fault_max - 8'd1);

      if (clr_fault) begin
         stuck_d = 1'b0;
         open_d  = 1'b0;
      end
      if (w_set && (state_q == ST_RELEASED)) begin
         stuck_d = 1'b1;
      end
      if (w_set && (state_q == ST_DRIVING)) begin
         open_d = 1'b1;
      end
   end

   assign nand_q = (state_q == ST_RELEASED);
   assign z_oe   = ~nand_q;
   assign z      = sync_q[SYNC_STAGES-1];
   assign stuck  = stuck_q;
   assign open   = open_q;

endmodule
`default_nettype wire
